// File: rtl/router_port_tx.sv
// Bit-serial packet transmitter for one router input port: captures a (da, data)
// request and shifts it out as address, padding and payload on frame_n/valid_n/di.
module router_port_tx #(
  parameter int PAD_CYCLES = 10,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_da,
  input  logic [31:0]      req_data,
  output logic             frame_n,
  output logic             valid_n,
  output logic             di,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count
);

  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_PAD, ST_DATA, ST_GAP} state_t;

  localparam logic [7:0] PAD_LAST = 8'(PAD_CYCLES - 1);

  state_t           state_r, state_s;
  logic [1:0]       addr_idx_r, addr_idx_s;
  logic [7:0]       pad_cnt_r, pad_cnt_s;
  logic [4:0]       data_idx_r, data_idx_s;
  logic [3:0]       da_r, da_src_s;
  logic [31:0]      data_r;
  logic             accept_s, pkt_done_s;
  logic             frame_s, valid_s, di_s, ready_s, busy_s;
  logic             req_ready_r, frame_r, valid_r, di_r, busy_r;
  logic [CNT_W-1:0] pkt_count_r;

  assign accept_s = req_valid && req_ready_r;
  // On the accept edge the address register is not loaded yet, so bit 0 comes straight from the request.
  assign da_src_s = accept_s ? req_da : da_r;

  // Next-state and per-state counter sequencing.
  always_comb begin
    state_s    = state_r;
    addr_idx_s = addr_idx_r;
    pad_cnt_s  = pad_cnt_r;
    data_idx_s = data_idx_r;
    pkt_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s    = ST_ADDR;
          addr_idx_s = 2'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (addr_idx_r == 2'd3) begin
          if (PAD_CYCLES == 0) begin
            state_s    = ST_DATA;
            data_idx_s = 5'd0;
          end else begin
            state_s   = ST_PAD;
            pad_cnt_s = 8'd0;
          end
        end else begin
          addr_idx_s = addr_idx_r + 2'd1;
        end
      end
      ST_PAD: begin
        if (pad_cnt_r == PAD_LAST) begin
          state_s    = ST_DATA;
          data_idx_s = 5'd0;
        end else begin
          pad_cnt_s = pad_cnt_r + 8'd1;
        end
      end
      ST_DATA: begin
        if (data_idx_r == 5'd31) begin
          state_s    = ST_GAP;
          pkt_done_s = 1'b1;
        end else begin
          data_idx_s = data_idx_r + 5'd1;
        end
      end
      ST_GAP: begin
        if (accept_s) begin
          state_s    = ST_ADDR;
          addr_idx_s = 2'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Line values for the state being entered, so the registered outputs line up with the state.
  always_comb begin
    frame_s = 1'b1;
    valid_s = 1'b1;
    di_s    = 1'b0;
    ready_s = 1'b0;
    busy_s  = 1'b0;
    case (state_s)
      ST_IDLE, ST_GAP: begin
        ready_s = 1'b1;
      end
      ST_ADDR: begin
        frame_s = 1'b0;
        di_s    = da_src_s[addr_idx_s];
        busy_s  = 1'b1;
      end
      ST_PAD: begin
        frame_s = 1'b0;
        di_s    = 1'b1;
        busy_s  = 1'b1;
      end
      ST_DATA: begin
        frame_s = (data_idx_s == 5'd31);
        valid_s = 1'b0;
        di_s    = data_r[data_idx_s];
        busy_s  = 1'b1;
      end
      default: begin
        frame_s = 1'b1;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      addr_idx_r <= 2'd0;
      pad_cnt_r  <= 8'd0;
      data_idx_r <= 5'd0;
    end else begin
      state_r    <= state_s;
      addr_idx_r <= addr_idx_s;
      pad_cnt_r  <= pad_cnt_s;
      data_idx_r <= data_idx_s;
    end
  end

  // Request capture; only an accepted request may change the held address and payload.
  always_ff @(posedge clock) begin
    if (reset) begin
      da_r   <= 4'd0;
      data_r <= 32'd0;
    end else if (accept_s) begin
      da_r   <= req_da;
      data_r <= req_data;
    end
  end

  // Registered protocol outputs, handshake and packet counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_r     <= 1'b1;
      valid_r     <= 1'b1;
      di_r        <= 1'b0;
      req_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      pkt_count_r <= '0;
    end else begin
      frame_r     <= frame_s;
      valid_r     <= valid_s;
      di_r        <= di_s;
      req_ready_r <= ready_s;
      busy_r      <= busy_s;
      if (pkt_done_s) begin
        pkt_count_r <= pkt_count_r + CNT_W'(1);
      end
    end
  end

  assign frame_n   = frame_r;
  assign valid_n   = valid_r;
  assign di        = di_r;
  assign req_ready = req_ready_r;
  assign busy      = busy_r;
  assign pkt_count = pkt_count_r;

endmodule

// File: tb/tb_router_port_tx.sv
// Bench for router_port_tx: a default build and a PAD_CYCLES=0 / 2-bit counter build,
// each checked every cycle against a queue of expected line values.
module tb_router_port_tx;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [3:0]  da0 = 4'd0, da1 = 4'd0;
  logic [31:0] d0 = 32'd0, d1 = 32'd0;
  logic        rdy0, fr0, vn0, di0, busy0;
  logic        rdy1, fr1, vn1, di1, busy1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  router_port_tx #(.PAD_CYCLES(10), .CNT_W(16)) dut0 (
    .clock(clock), .reset(reset), .req_valid(v0), .req_ready(rdy0),
    .req_da(da0), .req_data(d0), .frame_n(fr0), .valid_n(vn0), .di(di0),
    .busy(busy0), .pkt_count(cnt0));

  router_port_tx #(.PAD_CYCLES(0), .CNT_W(2)) dut1 (
    .clock(clock), .reset(reset), .req_valid(v1), .req_ready(rdy1),
    .req_da(da1), .req_data(d1), .frame_n(fr1), .valid_n(vn1), .di(di1),
    .busy(busy1), .pkt_count(cnt1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One model element per line cycle: {last_payload_bit, frame_n, valid_n, di}
  function automatic logic [3:0] pkt_bit(input int i, input int pad, input logic [3:0] da,
                                         input logic [31:0] d);
    int k;
    if (i < 4) return {3'b001, da[i]};
    if (i < 4 + pad) return 4'b0011;
    k = i - 4 - pad;
    if (k < 32) return {k == 31, k == 31, 1'b0, d[k]};
    return 4'b0110;
  endfunction

  logic [3:0]  q0[$];
  logic [3:0]  q1[$];
  int unsigned mc0 = 0, mc1 = 0;
  logic        mr0 = 1'b0, mr1 = 1'b0;

  // Reference model: a packet is a fixed waveform pushed on accept and consumed one cycle per edge
  initial begin
    logic [3:0] e;
    logic       acc;
    forever begin
      @(posedge clock);
      if (reset) begin
        q0.delete(); q1.delete(); mc0 = 0; mc1 = 0; mr0 = 1'b0; mr1 = 1'b0;
      end else begin
        acc = v0 && mr0;
        if (q0.size() > 0) begin e = q0.pop_front(); if (e[3]) mc0++; end
        if (acc) for (int i = 0; i < 37 + 10; i++) q0.push_back(pkt_bit(i, 10, da0, d0));
        mr0 = (q0.size() <= 1);
        acc = v1 && mr1;
        if (q1.size() > 0) begin e = q1.pop_front(); if (e[3]) mc1++; end
        if (acc) for (int i = 0; i < 37; i++) q1.push_back(pkt_bit(i, 0, da1, d1));
        mr1 = (q1.size() <= 1);
      end
    end
  end

  // Per-cycle comparison of every output against the model, on the falling edge
  initial begin
    logic [3:0] e;
    @(posedge clock);
    forever begin
      @(negedge clock);
      e = (q0.size() > 0) ? q0[0] : 4'b0110;
      check("line0", {11'd0, cnt0, busy0, rdy0, fr0, vn0, di0},
            {11'd0, mc0[15:0], q0.size() > 1, mr0, e[2:0]});
      e = (q1.size() > 0) ? q1[0] : 4'b0110;
      check("line1", {25'd0, cnt1, busy1, rdy1, fr1, vn1, di1},
            {25'd0, mc1[1:0], q1.size() > 1, mr1, e[2:0]});
    end
  end

  function automatic logic rdy_of(input int which);
    return (which == 1) ? rdy1 : rdy0;
  endfunction

  task automatic send(input int which, input logic [3:0] da, input logic [31:0] d);
    int n = 0;
    if (which == 1) begin v1 = 1'b1; da1 = da; d1 = d; end
    else begin v0 = 1'b1; da0 = da; d0 = d; end
    while (!rdy_of(which) && n < 200) begin @(negedge clock); n++; end
    if (n >= 200) check("send_timeout", 32'd0, 32'd1);
    @(negedge clock);
    if (which == 1) v1 = 1'b0; else v0 = 1'b0;
  endtask

  task automatic wait_idle(input int which);
    int n = 0;
    while (((which == 1) ? busy1 : busy0) && n < 300) begin @(negedge clock); n++; end
    if (n >= 300) check("idle_timeout", 32'd0, 32'd1);
    @(negedge clock);
  endtask

  initial begin
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", {31'd0, rdy0}, 32'd1);

    send(0, 4'd7, 32'hDEADBEEF);
    wait_idle(0);
    check("smoke_count", {16'd0, cnt0}, 32'd1);

    for (int k = 0; k < 10; k++) send(0, 4'(k % 8), $urandom);
    wait_idle(0);
    check("b2b_count", {16'd0, cnt0}, 32'd11);

    send(0, 4'd2, 32'hA5A5_0F0F);
    repeat (6) @(negedge clock);
    v0 = 1'b1; da0 = 4'd5; d0 = $urandom;
    @(negedge clock);
    v0 = 1'b0;
    wait_idle(0);
    check("ignored_count", {16'd0, cnt0}, 32'd12);

    send(0, 4'd4, $urandom);
    repeat (29) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_lines", {30'd0, fr0, vn0}, 32'd3);
    check("midrst_count", {16'd0, cnt0}, 32'd0);
    reset = 1'b0;
    send(0, 4'd1, 32'h55555555);
    wait_idle(0);
    check("after_rst_count", {16'd0, cnt0}, 32'd1);

    send(1, 4'd3, 32'h12345678);
    wait_idle(1);
    check("pad0_count", {30'd0, cnt1}, 32'd1);
    for (int k = 0; k < 4; k++) send(1, 4'(k + 8), $urandom);
    wait_idle(1);
    check("wrap_count", {30'd0, cnt1}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_port_tx.md
# router_port_tx

Serial packet transmitter for one input port of the 8x8 router. It accepts a parallel request (4-bit destination address plus 32-bit payload) over a valid/ready handshake. It then drives the router's bit-serial ingress protocol on that port's `frame_n`, `valid_n` and `di` lines. It is the hardware counterpart of the per-port receive monitor, and is instantiated once per router input.

## Interface
Parameters:
- `PAD_CYCLES`, 10, number of padding cycles between the address and the payload (legal range 0–255).
- `CNT_W`, 16, width of the sent-packet counter.

Ports:
- `clock`, input, 1, single clock; all logic is on the rising edge.
- `reset`, input, 1, synchronous, active-high.
- `req_valid`, input, 1, request present.
- `req_ready`, output, 1, transmitter can accept a request this cycle.
- `req_da`, input, 4, destination address.
- `req_data`, input, 32, payload.
- `frame_n`, output, 1, active-low frame, to router `frame_n[p]`.
- `valid_n`, output, 1, active-low payload valid, to router `valid_n[p]`.
- `di`, output, 1, serial data, to router `di[p]`.
- `busy`, output, 1, a packet is in flight (not IDLE or GAP).
- `pkt_count`, output, CNT_W, count of completed packets; wraps modulo 2^CNT_W.

## Operation
- A request is accepted on any rising edge where `req_valid && req_ready`. `req_da` and `req_data` are captured into internal registers at that edge. Inputs are don't-care at all other times.
- `req_ready` = 1 in IDLE and GAP, 0 otherwise, and 0 while `reset` is high.
- FSM states: IDLE, ADDR, PAD, DATA, GAP.
  - IDLE: `frame_n`=1, `valid_n`=1, `di`=0. Moves to ADDR on accept.
  - ADDR: 4 cycles. `frame_n`=0, `valid_n`=1. `di` = da[0], da[1], da[2], da[3] in that order (LSB first). Moves to PAD, or directly to DATA if PAD_CYCLES=0.
  - PAD: PAD_CYCLES cycles. `frame_n`=0, `valid_n`=1, `di`=1.
  - DATA: 32 cycles, index i=0..31. `valid_n`=0, `di`=data[i] (LSB first). `frame_n`=0 for i<31 and 1 for i=31. `pkt_count` increments on the edge leaving DATA.
  - GAP: 1 cycle. `frame_n`=1, `valid_n`=1, `di`=0. On accept, moves to ADDR (back-to-back); otherwise moves to IDLE.
- All protocol outputs are registered; no combinational path from the request inputs to `frame_n`, `valid_n` or `di`.
- Counters: a 2-bit address index, an 8-bit pad counter and a 5-bit data index, each cleared on entry to its state.
- `req_da[3]` is transmitted unchanged; range checking is the router's responsibility.

## Timing
- Reset values: `frame_n`=1, `valid_n`=1, `di`=0, `req_ready`=0, `busy`=0, `pkt_count`=0. The FSM resets to IDLE. `req_ready` rises on the first edge after `reset` deasserts.
- Accept at edge T: the first address bit is visible after edge T (cycle T+1).
- Packet length: 4 + PAD_CYCLES + 32 cycles, plus 1 GAP cycle (47 cycles at default). `frame_n` is low for 4 + PAD_CYCLES + 31 cycles.
- Back-to-back: with `req_valid` held high, the next packet's first address bit follows the GAP cycle. Minimum packet-start spacing is 4 + PAD_CYCLES + 33 cycles.
- `req_valid` high outside IDLE/GAP: the request is ignored (not accepted). The requester must hold it until `req_ready` is seen.
- Reset mid-packet: at the next edge the outputs return to their idle values and the packet is abandoned. The abandoned packet is not counted, and `pkt_count` clears.
- `pkt_count` at all-ones wraps to 0 on the next completed packet.

## Test plan
- Smoke: after reset, send da=7, data=32'hDEADBEEF. Expect `di` address bits 1,1,1,0, then 10 cycles of `di`=1 with `valid_n`=1. Then 32 payload bits with `valid_n`=0, matching DEADBEEF LSB first; `frame_n` rises exactly on the bit-31 cycle. Expect `pkt_count`=1 and a monitor on the line to decode EF..DE correctly.
- Reset values: hold `reset` for 4 cycles. Check every output against its reset value each cycle; `req_ready`=1 one cycle after release.
- Back-to-back: hold `req_valid` high with 10 random payloads to da=0..7. Expect exactly one idle cycle between packets, `pkt_count`=10, and all payloads and addresses decoded correctly.
- PAD_CYCLES=0 build: send da=3, data=32'h12345678. Expect `valid_n`=0 on the cycle immediately after da[3] and a total frame length of 36 cycles.
- Reset mid-DATA: assert `reset` at payload bit 15. Next cycle expect `frame_n`=1, `valid_n`=1 and `pkt_count`=0. A following request (da=1, data=32'h55555555) is transmitted cleanly.
- Ignored request: pulse `req_valid` for one cycle during PAD. Expect no second packet, `pkt_count` to increment by only 1, and no change to the captured address or data.
